// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Brief    : Sequential MIPS multiply/divide unit holding HI/LO; one bit per
//            cycle with a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              c_CW    = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST  = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
  localparam logic [1:0]      c_IDLE  = 2'd0;
  localparam logic [1:0]      c_RUN   = 2'd1;
  localparam logic [1:0]      c_FIX   = 2'd2;
  localparam logic [5:0]      c_MTHI  = 6'h11;
  localparam logic [5:0]      c_MTLO  = 6'h13;
  localparam logic [5:0]      c_MULT  = 6'h18;
  localparam logic [5:0]      c_MULTU = 6'h19;
  localparam logic [5:0]      c_DIV   = 6'h1A;
  localparam logic [5:0]      c_DIVU  = 6'h1B;

  logic [1:0]         r_state, w_state_nxt;
  logic [c_CW-1:0]    r_cnt;
  logic               r_is_div, r_signed, r_sign_a, r_sign_b;
  logic [WIDTH-1:0]   r_a, r_b, r_a_raw, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_done, r_dbz;

  logic               w_is_md, w_sign_a, w_sign_b, w_neg, w_qbit;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_rem_nxt, w_q, w_r, w_hi_fix, w_lo_fix;
  logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_prod;

  assign w_is_md  = (funct == c_MULT) || (funct == c_MULTU) ||
                    (funct == c_DIV)  || (funct == c_DIVU);
  // funct[0]==0 selects the signed variants (MULT, DIV)
  assign w_sign_a = ~funct[0] & operandA[WIDTH-1];
  assign w_sign_b = ~funct[0] & operandB[WIDTH-1];
  assign w_abs_a  = w_sign_a ? -operandA : operandA;
  assign w_abs_b  = w_sign_b ? -operandB : operandB;

  // Multiply step: add multiplicand into the upper half, shift right
  assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_b[0] ? r_a : '0)};
  // Divide step: upper half is the remainder, lower half collects quotient bits
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  assign w_neg  = r_signed & (r_sign_a ^ r_sign_b);
  assign w_prod = w_neg ? -r_acc : r_acc;
  assign w_q    = w_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r    = (r_signed & r_sign_a) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b == '0) begin
        w_hi_fix = r_a_raw;
        w_lo_fix = '1;
      end else begin
        w_hi_fix = w_r;
        w_lo_fix = w_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start && w_is_md) w_state_nxt = c_RUN;
      c_RUN:   if (r_cnt == c_LAST)  w_state_nxt = c_FIX;
      c_FIX:   w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != c_IDLE);
    done        = r_done;
    div_by_zero = r_dbz;
    hi          = r_hi;
    lo          = r_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_a_raw  <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        c_IDLE: if (start) begin
          if (funct == c_MTHI) r_hi <= operandA;
          if (funct == c_MTLO) r_lo <= operandA;
          if (w_is_md) begin
            r_is_div <= funct[1];
            r_signed <= ~funct[0];
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_a      <= w_abs_a;
            r_b      <= w_abs_b;
            r_a_raw  <= operandA;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        c_RUN: begin
          r_cnt <= r_cnt + c_ONE;
          if (r_is_div) begin
            r_acc <= {w_rem_nxt, r_acc[WIDTH-2:0], w_qbit};
            r_a   <= r_a << 1;
          end else begin
            r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            r_b   <= r_b >> 1;
          end
        end
        c_FIX: begin
          r_hi   <= w_hi_fix;
          r_lo   <= w_lo_fix;
          r_done <= 1'b1;
          r_dbz  <= r_is_div & (r_b == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
